// File: rtl/vc_ctrl_nway_pkg.sv
// Shared types for the N-way victim-cache controller: FSM state encoding
// and width helpers derived from the entry count and address geometry.
// No ports; imported by vc_ctrl_nway and vc_lru_ages.
package lc3b_types;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOOKUP    = 4'd1,
    HIT_XFER  = 4'd2,
    READ_THRU = 4'd3,
    INS_CHK   = 4'd4,
    WB        = 4'd5,
    INSERT    = 4'd6,
    RESP      = 4'd7,
    FL_SCAN   = 4'd8,
    FL_WB     = 4'd9,
    FL_DONE   = 4'd10
  } vc_state_t;

  // Index width for an entry count (entry count is a power of two, >= 2).
  function automatic int vc_idx_w(input int num_entries);
    return $clog2(num_entries);
  endfunction

  // Tag width: address bits above the line offset.
  function automatic int vc_tag_w(input int addr_width, input int offset_bits);
    return addr_width - offset_bits;
  endfunction

  // Widths for the default 4-entry, 16-bit address, 16-byte line geometry.
  localparam int VC_IDX_W = vc_idx_w(4);
  localparam int VC_TAG_W = vc_tag_w(16, 4);

endpackage

// File: rtl/vc_lru_ages.sv
// Per-entry age array for true-LRU replacement; age 0 = most recent.
// Latency: touch takes effect on the next clock; lru_idx is combinational.
// Ports: clk/rst, touch + touch_idx (mark entry most recent), lru_idx (age N-1).
module vc_lru_ages
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           touch,
  input  logic [$clog2(NUM_ENTRIES)-1:0] touch_idx,
  output logic [$clog2(NUM_ENTRIES)-1:0] lru_idx
);

  localparam int IDX_W = vc_idx_w(NUM_ENTRIES);

  logic [IDX_W-1:0] age [NUM_ENTRIES];
  logic [IDX_W-1:0] old_age;

  assign old_age = age[touch_idx];

  // Touched entry becomes 0; entries younger than it age by one. Entries
  // older than it keep their age, so the set remains a permutation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        age[i] <= IDX_W'(i);
      end
    end else if (touch) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx) begin
          age[i] <= '0;
        end else if (age[i] < old_age) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (age[i] == IDX_W'(NUM_ENTRIES - 1)) begin
        lru_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vc_ctrl_nway.sv
// Fully-associative N-entry victim cache controller between L2 and memory:
// owns tag/valid/dirty/LRU, steers an external data RAM by index, and
// handles fetch (hit/miss), victim insert with write-back, and flush.
// Latency: fetch hit -> l2_resp 3 cycles after accept; clean insert -> 4.
// Backpressure: L2 holds requests until l2_resp; pmem strobes held until pmem_resp.
// Ports: l2_* request/response, dram_idx/dram_we RAM steering, rdata_sel
// data mux, flush/flush_done, busy, pmem_* memory handshake.
module vc_ctrl_nway
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           l2_read,
  input  logic                           l2_write,
  input  logic [ADDR_WIDTH-1:0]          l2_addr,
  input  logic [ADDR_WIDTH-1:0]          l2_victim_addr,
  input  logic                           l2_victim_dirty,
  output logic                           l2_resp,
  output logic                           l2_hit,
  output logic                           l2_rdirty,
  output logic                           rdata_sel,
  output logic [$clog2(NUM_ENTRIES)-1:0] dram_idx,
  output logic                           dram_we,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           busy,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [ADDR_WIDTH-1:0]          pmem_addr,
  input  logic                           pmem_resp
);

  localparam int IDX_W = vc_idx_w(NUM_ENTRIES);
  localparam int TAG_W = vc_tag_w(ADDR_WIDTH, OFFSET_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  vc_state_t state;

  // Registered request
  logic             req_read;
  logic             req_write;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] vic_tag;
  logic             vic_dirty;

  // Entry state
  logic [TAG_W-1:0]       tag_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] dirty;

  logic [IDX_W-1:0] hit_idx_q;
  logic [IDX_W-1:0] target_q;
  logic [IDX_W-1:0] ptr;
  logic             l2_hit_q;
  logic             l2_rdirty_q;

  // Lookup results
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             dup;
  logic [IDX_W-1:0] dup_idx;
  logic             inv_any;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] ins_target;
  logic [IDX_W-1:0] lru_idx;
  logic             lru_touch;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{l2_addr[OFFSET_BITS-1:0], l2_victim_addr[OFFSET_BITS-1:0]};

  // Descending scan so the lowest matching index wins each encoder.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    dup     = 1'b0;
    dup_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tag_mem[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (valid[i] && (tag_mem[i] == vic_tag)) begin
        dup     = 1'b1;
        dup_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  // A line already present is overwritten in place so the VC never holds
  // two copies of the same tag.
  always_comb begin
    if (dup) begin
      ins_target = dup_idx;
    end else if (inv_any) begin
      ins_target = inv_idx;
    end else begin
      ins_target = lru_idx;
    end
  end

  assign lru_touch = (state == INSERT);

  vc_lru_ages #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_lru (
    .clk      (clk),
    .rst      (reset),
    .touch    (lru_touch),
    .touch_idx(target_q),
    .lru_idx  (lru_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_read    <= 1'b0;
      req_write   <= 1'b0;
      req_tag     <= '0;
      vic_tag     <= '0;
      vic_dirty   <= 1'b0;
      valid       <= '0;
      dirty       <= '0;
      hit_idx_q   <= '0;
      target_q    <= '0;
      ptr         <= '0;
      l2_hit_q    <= 1'b0;
      l2_rdirty_q <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (l2_read || l2_write) begin
            req_read    <= l2_read;
            req_write   <= l2_write;
            req_tag     <= l2_addr[ADDR_WIDTH-1:OFFSET_BITS];
            vic_tag     <= l2_victim_addr[ADDR_WIDTH-1:OFFSET_BITS];
            vic_dirty   <= l2_victim_dirty;
            l2_hit_q    <= 1'b0;
            l2_rdirty_q <= 1'b0;
            state       <= LOOKUP;
          end else if (flush) begin
            ptr   <= '0;
            state <= FL_SCAN;
          end
        end
        LOOKUP: begin
          if (req_read && hit) begin
            hit_idx_q <= hit_idx;
            state     <= HIT_XFER;
          end else if (req_read) begin
            state <= READ_THRU;
          end else begin
            state <= INS_CHK;
          end
        end
        HIT_XFER: begin
          l2_hit_q    <= 1'b1;
          l2_rdirty_q <= dirty[hit_idx_q];
          if (req_write) begin
            // Swap: the victim lands in the slot just vacated by the hit line.
            target_q <= hit_idx_q;
            state    <= INSERT;
          end else begin
            // Exclusive with L2: the line now lives only in L2.
            valid[hit_idx_q] <= 1'b0;
            dirty[hit_idx_q] <= 1'b0;
            state            <= RESP;
          end
        end
        READ_THRU: begin
          if (pmem_resp) begin
            l2_hit_q    <= 1'b0;
            l2_rdirty_q <= 1'b0;
            state       <= req_write ? INS_CHK : RESP;
          end
        end
        INS_CHK: begin
          target_q <= ins_target;
          state    <= (valid[ins_target] && dirty[ins_target]) ? WB : INSERT;
        end
        WB: begin
          if (pmem_resp) begin
            state <= INSERT;
          end
        end
        INSERT: begin
          tag_mem[target_q] <= vic_tag;
          valid[target_q]   <= 1'b1;
          dirty[target_q]   <= vic_dirty;
          state             <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        FL_SCAN: begin
          if (valid[ptr] && dirty[ptr]) begin
            state <= FL_WB;
          end else if (ptr == LAST_IDX) begin
            state <= FL_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        FL_WB: begin
          if (pmem_resp) begin
            dirty[ptr] <= 1'b0;
            if (ptr == LAST_IDX) begin
              state <= FL_DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FL_SCAN;
            end
          end
        end
        FL_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore outputs: decoded from state and registered indices only.
  assign l2_resp    = (state == RESP);
  assign l2_hit     = l2_hit_q;
  assign l2_rdirty  = l2_rdirty_q;
  assign rdata_sel  = (state == HIT_XFER);
  assign dram_we    = (state == INSERT);
  assign flush_done = (state == FL_DONE);
  assign busy       = (state != IDLE);
  assign pmem_read  = (state == READ_THRU);
  assign pmem_write = (state == WB) || (state == FL_WB);

  always_comb begin
    case (state)
      HIT_XFER:   dram_idx = hit_idx_q;
      WB, INSERT: dram_idx = target_q;
      FL_WB:      dram_idx = ptr;
      default:    dram_idx = '0;
    endcase
  end

  always_comb begin
    case (state)
      READ_THRU: pmem_addr = {req_tag, {OFFSET_BITS{1'b0}}};
      WB:        pmem_addr = {tag_mem[target_q], {OFFSET_BITS{1'b0}}};
      FL_WB:     pmem_addr = {tag_mem[ptr], {OFFSET_BITS{1'b0}}};
      default:   pmem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_vc_ctrl_nway.sv
// Directed bench for vc_ctrl_nway: three instances (4, 8 and 2 entries)
// driven one at a time, with a simple memory responder of programmable delay.
module tb_vc_ctrl_nway;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd [3];
  logic        wr [3];
  logic        vd [3];
  logic        fl [3];
  logic        presp [3];
  logic [15:0] addr [3];
  logic [15:0] vaddr [3];

  logic        resp [3];
  logic        hit [3];
  logic        rdirty [3];
  logic        rsel [3];
  logic        we [3];
  logic        fdone [3];
  logic        bsy [3];
  logic        pread [3];
  logic        pwrite [3];
  logic [15:0] paddr [3];
  logic [3:0]  didx [3];

  logic [1:0] didx4;
  logic [2:0] didx8;
  logic [0:0] didx2;
  assign didx[0] = {2'b00, didx4};
  assign didx[1] = {1'b0, didx8};
  assign didx[2] = {3'b000, didx2};

  vc_ctrl_nway #(.NUM_ENTRIES(4)) u_dut4 (
    .clk(clk), .reset(rst), .l2_read(rd[0]), .l2_write(wr[0]), .l2_addr(addr[0]),
    .l2_victim_addr(vaddr[0]), .l2_victim_dirty(vd[0]), .l2_resp(resp[0]),
    .l2_hit(hit[0]), .l2_rdirty(rdirty[0]), .rdata_sel(rsel[0]), .dram_idx(didx4),
    .dram_we(we[0]), .flush(fl[0]), .flush_done(fdone[0]), .busy(bsy[0]),
    .pmem_read(pread[0]), .pmem_write(pwrite[0]), .pmem_addr(paddr[0]), .pmem_resp(presp[0])
  );

  vc_ctrl_nway #(.NUM_ENTRIES(8)) u_dut8 (
    .clk(clk), .reset(rst), .l2_read(rd[1]), .l2_write(wr[1]), .l2_addr(addr[1]),
    .l2_victim_addr(vaddr[1]), .l2_victim_dirty(vd[1]), .l2_resp(resp[1]),
    .l2_hit(hit[1]), .l2_rdirty(rdirty[1]), .rdata_sel(rsel[1]), .dram_idx(didx8),
    .dram_we(we[1]), .flush(fl[1]), .flush_done(fdone[1]), .busy(bsy[1]),
    .pmem_read(pread[1]), .pmem_write(pwrite[1]), .pmem_addr(paddr[1]), .pmem_resp(presp[1])
  );

  vc_ctrl_nway #(.NUM_ENTRIES(2)) u_dut2 (
    .clk(clk), .reset(rst), .l2_read(rd[2]), .l2_write(wr[2]), .l2_addr(addr[2]),
    .l2_victim_addr(vaddr[2]), .l2_victim_dirty(vd[2]), .l2_resp(resp[2]),
    .l2_hit(hit[2]), .l2_rdirty(rdirty[2]), .rdata_sel(rsel[2]), .dram_idx(didx2),
    .dram_we(we[2]), .flush(fl[2]), .flush_done(fdone[2]), .busy(bsy[2]),
    .pmem_read(pread[2]), .pmem_write(pwrite[2]), .pmem_addr(paddr[2]), .pmem_resp(presp[2])
  );

  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations
  int          r_cyc;
  int          r_we_cnt;
  int          r_we_idx;
  int          r_pr_cyc;
  int          r_pr_cnt;
  int          r_rsel_cnt;
  int          r_rsel_idx;
  int          r_fdone;
  int          wcnt;
  logic        r_hit;
  logic        r_rdirty;
  logic        r_wb_first;
  logic [15:0] r_pr_addr;
  logic [15:0] r_pw_addr [$];

  task automatic clear_rec();
    r_cyc = 0; r_we_cnt = 0; r_we_idx = -1; r_pr_cyc = 0; r_pr_cnt = 0;
    r_rsel_cnt = 0; r_rsel_idx = -1; r_fdone = 0; wcnt = 0;
    r_hit = 1'b0; r_rdirty = 1'b0; r_wb_first = 1'b0; r_pr_addr = '0;
    r_pw_addr.delete();
  endtask

  // One clock: sample just after the edge, then play the memory side.
  task automatic step(input int s, input int dly);
    @(posedge clk);
    #1;
    if (we[s]) begin r_we_cnt++; r_we_idx = int'(didx[s]); end
    if (rsel[s]) begin r_rsel_cnt++; r_rsel_idx = int'(didx[s]); end
    if (fdone[s]) r_fdone++;
    if (pread[s]) begin r_pr_cyc++; r_pr_addr = paddr[s]; end
    if (presp[s]) begin
      presp[s] = 1'b0;
      wcnt = 0;
    end else if (pread[s] || pwrite[s]) begin
      wcnt++;
      if (wcnt == 1 && pread[s]) r_pr_cnt++;
      if (wcnt == 1 && pwrite[s]) begin
        r_pw_addr.push_back(paddr[s]);
        if (r_we_cnt == 0) r_wb_first = 1'b1;
      end
      if (wcnt >= dly) presp[s] = 1'b1;
    end
  endtask

  task automatic txn(input int s, input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] va, input logic v_d, input int dly);
    clear_rec();
    @(negedge clk);
    rd[s] = r; wr[s] = w; addr[s] = a; vaddr[s] = va; vd[s] = v_d;
    for (int c = 1; c <= 100; c++) begin
      step(s, dly);
      if (resp[s]) begin
        r_cyc = c; r_hit = hit[s]; r_rdirty = rdirty[s];
        break;
      end
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
    chk($sformatf("s%0d_a%0h_v%0h_resp_seen", s, a, va), 32'(r_cyc != 0), 32'd1);
    @(posedge clk);
    #1;
    chk($sformatf("s%0d_a%0h_v%0h_resp_pulse", s, a, va), {30'd0, resp[s], bsy[s]}, 32'd0);
  endtask

  task automatic do_flush(input int s);
    clear_rec();
    @(negedge clk);
    fl[s] = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step(s, 1);
      if (c == 1) fl[s] = 1'b0;
      if (fdone[s]) begin r_cyc = c; break; end
    end
    fl[s] = 1'b0;
    step(s, 1);
    chk($sformatf("s%0d_flush_done_seen", s), 32'(r_cyc != 0), 32'd1);
  endtask

  task automatic do_reset(input int s);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 0; wr[k] = 0; vd[k] = 0; fl[k] = 0; presp[k] = 0; addr[k] = 0; vaddr[k] = 0;
    end
    wcnt = 0;
    #1;
    chk($sformatf("s%0d_reset_outputs", s),
        {16'd0, resp[s], hit[s], rdirty[s], rsel[s], we[s], fdone[s], bsy[s], pread[s],
         pwrite[s], didx[s][2:0], 4'd0}, 32'd0);
    chk($sformatf("s%0d_reset_pmem_addr", s), 32'(paddr[s]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int   n;
  logic seen;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_rec();
    #2;

    // Tests 1-3 on each geometry; the 4-entry instance goes last so its
    // state carries into the remaining tests.
    for (int k = 2; k >= 0; k--) begin
      n = (k == 0) ? 4 : ((k == 1) ? 8 : 2);
      do_reset(k);

      // 1: clean write-only insert
      txn(k, 0, 1, 16'h0000, 16'h1230, 0, 1);
      chk($sformatf("N%0d_t1_latency", n), r_cyc, 4);
      chk($sformatf("N%0d_t1_we_cnt", n), r_we_cnt, 1);
      chk($sformatf("N%0d_t1_we_idx", n), r_we_idx, 0);
      chk($sformatf("N%0d_t1_pmem", n), r_pr_cnt + r_pw_addr.size(), 0);

      // 2: fill, LRU replace clean, then LRU replace dirty with write-back
      do_reset(k);
      for (int i = 0; i < n; i++) begin
        txn(k, 0, 1, 16'h0000, 16'h1000 + 16'(16 * i), (i == 1), 1);
        chk($sformatf("N%0d_t2_fill%0d_idx", n, i), r_we_idx, i);
      end
      txn(k, 0, 1, 16'h0000, 16'h2000, 0, 1);
      chk($sformatf("N%0d_t2_lru_idx", n), r_we_idx, 0);
      chk($sformatf("N%0d_t2_lru_no_wb", n), r_pw_addr.size(), 0);
      txn(k, 0, 1, 16'h0000, 16'h2010, 0, 1);
      chk($sformatf("N%0d_t2_wb_cnt", n), r_pw_addr.size(), 1);
      chk($sformatf("N%0d_t2_wb_addr", n), (r_pw_addr.size() > 0) ? r_pw_addr[0] : 16'hxxxx, 16'h1010);
      chk($sformatf("N%0d_t2_wb_before_we", n), r_wb_first, 1);
      chk($sformatf("N%0d_t2_wb_we_idx", n), r_we_idx, 1);
      chk($sformatf("N%0d_t2_wb_latency", n), r_cyc, 5);

      // 3: dirty-overwrite of a present line, then fetch hit with swap
      txn(k, 0, 1, 16'h0000, 16'h2000, 1, 1);
      chk($sformatf("N%0d_t3_dup_idx", n), r_we_idx, 0);
      chk($sformatf("N%0d_t3_dup_no_wb", n), r_pw_addr.size(), 0);
      txn(k, 1, 1, 16'h2000, 16'h3000, 0, 1);
      chk($sformatf("N%0d_t3_hit", n), {r_hit, r_rdirty}, 2'b11);
      chk($sformatf("N%0d_t3_rsel_cnt", n), r_rsel_cnt, 1);
      chk($sformatf("N%0d_t3_rsel_idx", n), r_rsel_idx, 0);
      chk($sformatf("N%0d_t3_we_idx", n), r_we_idx, 0);
      chk($sformatf("N%0d_t3_pmem", n), r_pr_cnt + r_pw_addr.size(), 0);
      chk($sformatf("N%0d_t3_latency", n), r_cyc, 4);
    end

    // 4: miss with slow memory, no victim; offset bits must be cleared
    txn(0, 1, 0, 16'h4008, 16'h0000, 0, 5);
    chk("t4_hit", {r_hit, r_rdirty}, 2'b00);
    chk("t4_pread_cycles", r_pr_cyc, 5);
    chk("t4_pread_cnt", r_pr_cnt, 1);
    chk("t4_pmem_addr", r_pr_addr, 16'h4000);
    chk("t4_no_we_no_wb", r_we_cnt + r_pw_addr.size(), 0);
    chk("t4_latency", r_cyc, 7);
    txn(0, 1, 0, 16'h3000, 16'h0000, 0, 1);
    chk("t4_vc_kept_hit", {r_hit, r_rdirty}, 2'b10);
    chk("t4_vc_kept_latency", r_cyc, 3);
    chk("t4_vc_kept_no_we", r_we_cnt, 0);
    txn(0, 1, 0, 16'h3000, 16'h0000, 0, 1);
    chk("t4_invalidated_miss", r_hit, 0);
    chk("t4_invalidated_pread", r_pr_cnt, 1);

    // 5: two dirty entries (invalid slot 0, duplicate slot 3), then flush
    txn(0, 0, 1, 16'h0000, 16'h5000, 1, 1);
    chk("t5_inv_first_idx", r_we_idx, 0);
    txn(0, 0, 1, 16'h0000, 16'h1030, 1, 1);
    chk("t5_dup_idx", r_we_idx, 3);
    do_flush(0);
    chk("t5_flush_wr_cnt", r_pw_addr.size(), 2);
    chk("t5_flush_wr0", (r_pw_addr.size() > 0) ? r_pw_addr[0] : 16'hxxxx, 16'h5000);
    chk("t5_flush_wr1", (r_pw_addr.size() > 1) ? r_pw_addr[1] : 16'hxxxx, 16'h1030);
    chk("t5_flush_done_pulses", r_fdone, 1);
    do_flush(0);
    chk("t5_reflush_no_wr", r_pw_addr.size(), 0);
    txn(0, 1, 0, 16'h1030, 16'h0000, 0, 1);
    chk("t5_valid_kept_clean", {r_hit, r_rdirty}, 2'b10);

    // 6: reset in the middle of a write-back
    do_reset(0);
    txn(0, 0, 1, 16'h0000, 16'h6000, 1, 1);
    txn(0, 0, 1, 16'h0000, 16'h6010, 0, 1);
    txn(0, 0, 1, 16'h0000, 16'h6020, 0, 1);
    txn(0, 0, 1, 16'h0000, 16'h6030, 0, 1);
    @(negedge clk);
    wr[0] = 1'b1; vaddr[0] = 16'h6040; vd[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (pwrite[0]) begin seen = 1'b1; break; end
    end
    chk("t6_wb_started", seen, 1);
    chk("t6_wb_addr", paddr[0], 16'h6000);
    #2;
    rst = 1'b1;
    wr[0] = 1'b0;
    #1;
    chk("t6_async_drop", {30'd0, pwrite[0], bsy[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1, 0, 16'h6010, 16'h0000, 0, 1);
    chk("t6_after_reset_miss", r_hit, 0);
    chk("t6_after_reset_pread", r_pr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
